sipo_deserializer: RTL and testbench

- Serial-in/parallel-out receiver: the far end of the serial line driven by the team's universal shift register in shift-out mode.
- Collects WIDTH bits framed by a start-of-frame strobe.
- Presents the assembled word on a registered output with a valid/ready handshake.
- Sits between a serial link and any parallel consumer; flags overrun and broken frames.

---
 rtl/sipo_pkg.sv | 21 ++
 rtl/sipo_shreg.sv | 59 +++++
 rtl/sipo_deserializer.sv | 149 ++++++++++++++
 tb/tb_sipo_deserializer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : sipo_pkg                                                |
// | Purpose  : Shared types and constants for the SIPO deserializer.   |
// |            sipo_state_t : receiver FSM states (IDLE, SHIFT)        |
// |            LSB_FIRST_C  : first serial bit lands in dout[0]        |
// |            MSB_FIRST_C  : first serial bit lands in dout[WIDTH-1]  |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
package sipo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } sipo_state_t;

  localparam bit LSB_FIRST_C = 1'b1;
  localparam bit MSB_FIRST_C = 1'b0;

endpackage : sipo_pkg
`default_nettype wire

// File: rtl/sipo_shreg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : sipo_shreg                                              |
// | Purpose  : WIDTH-bit capture register for the SIPO receiver.       |
// |            Synchronous clear, load-first-bit and shift-enable.     |
// | Ports    : clk    - system clock                                   |
// |            clr    - synchronous clear (highest priority)           |
// |            load   - start a new frame with sin as its first bit    |
// |            shift  - append sin to the frame in progress            |
// |            sin    - serial data bit                                |
// |            q_nxt  - register contents after this clock edge        |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module sipo_shreg
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          LSB_FIRST = LSB_FIRST_C
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             shift,
  input  logic             sin,
  output logic [WIDTH-1:0] q_nxt
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_loaded;

  // New bits always enter at the far end so that, after WIDTH bits, the
  // first bit of the frame has travelled to the end chosen by direction.
  // A load clears the stale partial word left behind by a restart.
  if (LSB_FIRST == LSB_FIRST_C) begin : g_lsb_first
    assign w_shifted = {sin, r_q[WIDTH-1:1]};
    assign w_loaded  = {sin, {(WIDTH-1){1'b0}}};
  end else begin : g_msb_first
    assign w_shifted = {r_q[WIDTH-2:0], sin};
    assign w_loaded  = {{(WIDTH-1){1'b0}}, sin};
  end

  always_comb begin
    q_nxt = r_q;
    if (clr) begin
      q_nxt = '0;
    end else if (load) begin
      q_nxt = w_loaded;
    end else if (shift) begin
      q_nxt = w_shifted;
    end
  end

  always_ff @(posedge clk) begin
    r_q <= q_nxt;
  end

endmodule : sipo_shreg
`default_nettype wire

// File: rtl/sipo_deserializer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : sipo_deserializer                                       |
// | Purpose  : Serial-in/parallel-out receiver with sof framing and a  |
// |            valid/ready output register.                            |
// | Ports    : clk, nrst        - clock, sync active-low reset         |
// |            sin, sin_valid   - serial bit and its strobe            |
// |            sof              - marks the current bit as bit 0       |
// |            dout, dout_valid - assembled word / word available      |
// |            dout_ready       - consumer accepts the word            |
// |            busy             - frame in progress                    |
// |            overrun          - pulse: completed word dropped        |
// |            frame_err        - pulse: partial word discarded by sof |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          LSB_FIRST = LSB_FIRST_C
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  sipo_state_t      r_state;
  sipo_state_t      w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;
  logic             r_overrun;
  logic             r_frame_err;

  logic             w_load;
  logic             w_shift;
  logic             w_complete;
  logic             w_restart;
  logic             w_out_load;
  logic [WIDTH-1:0] w_word;

  sipo_shreg #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_shreg (
    .clk   (clk),
    .clr   (~nrst),
    .load  (w_load),
    .shift (w_shift),
    .sin   (sin),
    .q_nxt (w_word)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------- FSM: next state and decode ----------------
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_complete  = 1'b0;
    w_restart   = 1'b0;
    case (r_state)
      IDLE: begin
        if (sin_valid && sof) begin
          w_load      = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (sin_valid && sof) begin
          w_load    = 1'b1;
          w_restart = 1'b1;
        end else if (sin_valid) begin
          w_shift = 1'b1;
          // r_cnt counts bits already held, so WIDTH-1 means this is the last.
          if (r_cnt == CW'(WIDTH - 1)) begin
            w_complete  = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // A finished word may enter the output register when it is empty or
  // is being drained in this very cycle (back-to-back transfer).
  assign w_out_load = w_complete && (!r_dout_valid || dout_ready);

  // ---------------- Bit counter ----------------
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_cnt <= '0;
    end else if (w_load) begin
      r_cnt <= CW'(1);
    end else if (w_complete) begin
      r_cnt <= '0;
    end else if (w_shift) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // ---------------- Output register and flags ----------------
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_overrun    <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_overrun   <= w_complete && r_dout_valid && !dout_ready;
      r_frame_err <= w_restart;
      if (w_out_load) begin
        r_dout       <= w_word;
        r_dout_valid <= 1'b1;
      end else if (dout_ready) begin
        r_dout_valid <= 1'b0;
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign busy       = (r_state == SHIFT);
  assign overrun    = r_overrun;
  assign frame_err  = r_frame_err;

endmodule : sipo_deserializer
`default_nettype wire

// File: tb/tb_sipo_deserializer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_sipo_deserializer                                    |
// | Purpose  : Directed self-checking bench; one LSB-first and one     |
// |            MSB-first instance share the same stimulus.             |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tb_sipo_deserializer;

  logic       clk = 1'b0;
  logic       nrst;
  logic       sin;
  logic       sin_valid;
  logic       sof;
  logic       dout_ready;

  logic [3:0] dout_l, dout_m;
  logic       dv_l, dv_m;
  logic       busy_l, busy_m;
  logic       ovr_l, ovr_m;
  logic       ferr_l, ferr_m;

  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(4), .LSB_FIRST(1'b1)) u_dut_l (
    .clk        (clk),
    .nrst       (nrst),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .sof        (sof),
    .dout       (dout_l),
    .dout_valid (dv_l),
    .dout_ready (dout_ready),
    .busy       (busy_l),
    .overrun    (ovr_l),
    .frame_err  (ferr_l)
  );

  sipo_deserializer #(.WIDTH(4), .LSB_FIRST(1'b0)) u_dut_m (
    .clk        (clk),
    .nrst       (nrst),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .sof        (sof),
    .dout       (dout_m),
    .dout_valid (dv_m),
    .dout_ready (dout_ready),
    .busy       (busy_m),
    .overrun    (ovr_m),
    .frame_err  (ferr_m)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One serial bit in exactly one cycle; the strobe drops afterwards.
  task automatic sb(input logic b, input logic f);
    sin       = b;
    sof       = f;
    sin_valid = 1'b1;
    tick();
    sin_valid = 1'b0;
    sof       = 1'b0;
  endtask

  // Whole frame, bit i = w[i] on the wire; the LSB-first instance rebuilds w.
  task automatic send_word(input logic [3:0] w);
    for (int i = 0; i < 4; i++) begin
      sb(w[i], i == 0);
    end
  endtask

  initial begin
    logic [3:0] w9;
    nrst       = 1'b0;
    sin        = 1'b0;
    sin_valid  = 1'b0;
    sof        = 1'b0;
    dout_ready = 1'b0;
    tick();
    tick();
    chk("rst_dout",  32'(dout_l), 32'h0);
    chk("rst_valid", 32'(dv_l),   32'h0);
    chk("rst_busy",  32'(busy_l), 32'h0);
    chk("rst_ovr",   32'(ovr_l),  32'h0);
    chk("rst_ferr",  32'(ferr_l), 32'h0);
    nrst = 1'b1;
    tick();

    // Test 1/2: bits 1,0,1,1 with ready high, both directions.
    dout_ready = 1'b1;
    sb(1'b1, 1'b1);
    chk("t1_busy_c2", 32'(busy_l), 32'h1);
    chk("t2_busy_c2", 32'(busy_m), 32'h1);
    sb(1'b0, 1'b0);
    chk("t1_busy_c3", 32'(busy_l), 32'h1);
    chk("t1_nvalid",  32'(dv_l),   32'h0);
    sb(1'b1, 1'b0);
    chk("t1_busy_c4", 32'(busy_l), 32'h1);
    sb(1'b1, 1'b0);
    chk("t1_dout",    32'(dout_l), 32'hD);
    chk("t1_valid",   32'(dv_l),   32'h1);
    chk("t1_busy_dn", 32'(busy_l), 32'h0);
    chk("t2_dout",    32'(dout_m), 32'hB);
    chk("t2_valid",   32'(dv_m),   32'h1);
    tick();
    chk("t1_valid_1cyc", 32'(dv_l),   32'h0);
    chk("t1_dout_keep",  32'(dout_l), 32'hD);
    chk("t2_valid_1cyc", 32'(dv_m),   32'h0);

    // Test 3: overrun with consumer stalled.
    dout_ready = 1'b0;
    send_word(4'hA);
    chk("t3_dout_a",  32'(dout_l), 32'hA);
    chk("t3_valid_a", 32'(dv_l),   32'h1);
    chk("t3_no_ovr",  32'(ovr_l),  32'h0);
    send_word(4'h5);
    chk("t3_ovr",     32'(ovr_l),  32'h1);
    chk("t3_dout_kp", 32'(dout_l), 32'hA);
    tick();
    chk("t3_ovr_1cyc", 32'(ovr_l), 32'h0);
    chk("t3_valid_kp", 32'(dv_l),  32'h1);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    chk("t3_valid_clr", 32'(dv_l), 32'h0);

    // Test 4: sof mid-frame restarts, then frame 0x3 completes.
    sb(1'b1, 1'b1);
    sb(1'b1, 1'b0);
    chk("t4_no_ferr", 32'(ferr_l), 32'h0);
    sb(1'b1, 1'b1);
    chk("t4_ferr",    32'(ferr_l), 32'h1);
    chk("t4_busy",    32'(busy_l), 32'h1);
    sb(1'b1, 1'b0);
    chk("t4_ferr_1cyc", 32'(ferr_l), 32'h0);
    sb(1'b0, 1'b0);
    chk("t4_not_done",  32'(dv_l),   32'h0);
    sb(1'b0, 1'b0);
    chk("t4_dout",  32'(dout_l), 32'h3);
    chk("t4_valid", 32'(dv_l),   32'h1);
    chk("t4_ovr",   32'(ovr_l),  32'h0);

    // Test 5: reset mid-frame, unframed bits, then frame 0x6.
    sb(1'b1, 1'b1);
    sb(1'b0, 1'b0);
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    chk("t5_dout",  32'(dout_l), 32'h0);
    chk("t5_valid", 32'(dv_l),   32'h0);
    chk("t5_busy",  32'(busy_l), 32'h0);
    chk("t5_ovr",   32'(ovr_l),  32'h0);
    chk("t5_ferr",  32'(ferr_l), 32'h0);
    sb(1'b1, 1'b0);
    sb(1'b1, 1'b0);
    chk("t5_unframed_busy",  32'(busy_l), 32'h0);
    chk("t5_unframed_valid", 32'(dv_l),   32'h0);
    send_word(4'h6);
    chk("t5_dout6",  32'(dout_l), 32'h6);
    chk("t5_valid6", 32'(dv_l),   32'h1);

    // Test 6: back-to-back 0xF -> 0x9 with gapped bits.
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    send_word(4'hF);
    chk("t6_dout_f", 32'(dout_l), 32'hF);
    w9 = 4'h9;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) dout_ready = 1'b1;
      sb(w9[i], i == 0);
      dout_ready = 1'b0;
      if (i < 3) begin
        for (int g = 0; g < 3; g++) tick();
        chk("t6_gap_dout",  32'(dout_l), 32'hF);
        chk("t6_gap_valid", 32'(dv_l),   32'h1);
      end
    end
    chk("t6_dout9",  32'(dout_l), 32'h9);
    chk("t6_valid9", 32'(dv_l),   32'h1);
    chk("t6_no_ovr", 32'(ovr_l),  32'h0);
    tick();
    chk("t6_valid_hold", 32'(dv_l),  32'h1);
    chk("t6_no_ovr2",    32'(ovr_l), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_sipo_deserializer
`default_nettype wire
